// File: rtl/rob_dispatch_ctrl.sv
// Reorder-buffer dispatch controller.
// Allocates up to two in-order ROB entries per cycle to the decode pair. It
// tracks the tail pointer and the free-entry count, and blocks dispatch for a
// fixed number of cycles after a branch mispredict squashes the ROB.
module rob_dispatch_ctrl #(
    parameter int ROB_NUM     = 64,
    parameter int ROB_SEL     = 6,
    parameter int RECOVER_CYC = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               req1_i,
    input  logic               req2_i,
    input  logic [1:0]         comnum_i,
    input  logic [ROB_SEL-1:0] commit_ptr_i,
    input  logic               prmiss_i,
    output logic               dp1_o,
    output logic [ROB_SEL-1:0] dp1_addr_o,
    output logic               dp2_o,
    output logic [ROB_SEL-1:0] dp2_addr_o,
    output logic               stall_o,
    output logic [ROB_SEL-1:0] dispatch_ptr_o,
    output logic [ROB_SEL:0]   freenum_o,
    output logic               full_o,
    output logic               empty_o,
    output logic               flush_o,
    output logic               err_o
);

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } stateT;

    // Sums are formed one bit wider than the free count so that an
    // over-credit (more commits than occupied entries) can be detected.
    localparam logic [ROB_SEL+1:0] ROB_NUM_W = (ROB_SEL+2)'(ROB_NUM);
    localparam logic [ROB_SEL:0]   ROB_NUM_F = (ROB_SEL+1)'(ROB_NUM);
    localparam logic [3:0]         CNT_INIT  = 4'(RECOVER_CYC - 1);

    stateT              r_state;
    logic [3:0]         r_cnt;
    logic [ROB_SEL-1:0] r_dispPtr;
    logic [ROB_SEL:0]   r_freeNum;
    logic               r_err;

    stateT              w_stateNext;
    logic [3:0]         w_cntNext;
    logic [ROB_SEL-1:0] w_dispPtrNext;
    logic [ROB_SEL:0]   w_freeNumNext;
    logic               w_errNext;

    logic [1:0]         w_need;
    logic [1:0]         w_grantCnt;
    logic               w_stall;
    logic               w_dp1;
    logic               w_dp2;
    logic [ROB_SEL+1:0] w_runSum;
    logic [ROB_SEL+1:0] w_recSum;

    // A second request without a first is ignored so dispatch stays in order.
    assign w_need     = {1'b0, req1_i} + {1'b0, req1_i & req2_i};
    // The stall uses the registered free count; commits arriving this cycle
    // only become visible to dispatch on the following cycle.
    assign w_stall    = (r_state == RECOVER) | prmiss_i
                      | ({{(ROB_SEL-1){1'b0}}, w_need} > r_freeNum);
    // The pair is granted all-or-nothing, and never during a reset cycle.
    assign w_dp1      = req1_i & ~w_stall & ~reset_i;
    assign w_dp2      = req1_i & req2_i & ~w_stall & ~reset_i;
    assign w_grantCnt = {1'b0, w_dp1} + {1'b0, w_dp2};

    assign w_runSum = {1'b0, r_freeNum} - {{ROB_SEL{1'b0}}, w_grantCnt}
                    + {{ROB_SEL{1'b0}}, comnum_i};
    assign w_recSum = {1'b0, r_freeNum} + {{ROB_SEL{1'b0}}, comnum_i};

    assign dp1_o          = w_dp1;
    assign dp2_o          = w_dp2;
    assign stall_o        = w_stall;
    assign dp1_addr_o     = r_dispPtr;
    assign dp2_addr_o     = r_dispPtr + {{(ROB_SEL-1){1'b0}}, 1'b1};
    assign dispatch_ptr_o = r_dispPtr;
    assign freenum_o      = r_freeNum;
    assign full_o         = (r_freeNum == '0);
    assign empty_o        = (r_freeNum == ROB_NUM_F);
    assign flush_o        = (r_state == RECOVER);
    assign err_o          = r_err;

    // Next-state logic: a mispredict squashes everything and (re)starts recovery.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_dispPtrNext = r_dispPtr;
        w_freeNumNext = r_freeNum;
        w_errNext     = r_err;
        if (prmiss_i) begin
            w_stateNext   = RECOVER;
            w_cntNext     = CNT_INIT;
            w_dispPtrNext = commit_ptr_i + {{(ROB_SEL-2){1'b0}}, comnum_i};
            w_freeNumNext = ROB_NUM_F;
        end else if (r_state == RUN) begin
            w_dispPtrNext = r_dispPtr + {{(ROB_SEL-2){1'b0}}, w_grantCnt};
            if (w_runSum > ROB_NUM_W) begin
                w_freeNumNext = ROB_NUM_F;
                w_errNext     = 1'b1;
            end else begin
                w_freeNumNext = w_runSum[ROB_SEL:0];
            end
        end else begin
            if (r_cnt == 4'd0) begin
                w_stateNext = RUN;
            end else begin
                w_cntNext = r_cnt - 4'd1;
            end
            // Late commits of already-squashed entries are simply saturated.
            if (w_recSum > ROB_NUM_W) begin
                w_freeNumNext = ROB_NUM_F;
            end else begin
                w_freeNumNext = w_recSum[ROB_SEL:0];
            end
        end
    end

    // State registers; reset outranks every input including a mispredict.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= RUN;
            r_cnt     <= 4'd0;
            r_dispPtr <= '0;
            r_freeNum <= ROB_NUM_F;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_dispPtr <= w_dispPtrNext;
            r_freeNum <= w_freeNumNext;
            r_err     <= w_errNext;
        end
    end

endmodule

// File: tb/tb_rob_dispatch_ctrl.sv
// Testbench for rob_dispatch_ctrl.
// Each cycle's expected outputs come from a small behavioural model, are
// queued when the stimulus is driven and compared when the outputs are sampled.
module tb_rob_dispatch_ctrl;

    localparam int ROB_NUM     = 64;
    localparam int ROB_SEL     = 6;
    localparam int RECOVER_CYC = 2;

    logic               clk;
    logic               resetIn;
    logic               req1;
    logic               req2;
    logic [1:0]         comnum;
    logic [ROB_SEL-1:0] commitPtr;
    logic               prmiss;
    logic               dp1;
    logic [ROB_SEL-1:0] dp1Addr;
    logic               dp2;
    logic [ROB_SEL-1:0] dp2Addr;
    logic               stall;
    logic [ROB_SEL-1:0] dispatchPtr;
    logic [ROB_SEL:0]   freenum;
    logic               full;
    logic               empty;
    logic               flush;
    logic               err;

    typedef struct {
        bit dp1;
        bit dp2;
        int a1;
        int a2;
        bit stall;
        int ptr;
        int fn;
        bit full;
        bit empty;
        bit flush;
        bit err;
    } expT;

    expT expQ[$];

    int mPtr;
    int mFn;
    int mCnt;
    bit mRecov;
    bit mErr;

    int compared   = 0;
    int mismatched = 0;

    rob_dispatch_ctrl #(
        .ROB_NUM     (ROB_NUM),
        .ROB_SEL     (ROB_SEL),
        .RECOVER_CYC (RECOVER_CYC)
    ) dut (
        .clk_i          (clk),
        .reset_i        (resetIn),
        .req1_i         (req1),
        .req2_i         (req2),
        .comnum_i       (comnum),
        .commit_ptr_i   (commitPtr),
        .prmiss_i       (prmiss),
        .dp1_o          (dp1),
        .dp1_addr_o     (dp1Addr),
        .dp2_o          (dp2),
        .dp2_addr_o     (dp2Addr),
        .stall_o        (stall),
        .dispatch_ptr_o (dispatchPtr),
        .freenum_o      (freenum),
        .full_o         (full),
        .empty_o        (empty),
        .flush_o        (flush),
        .err_o          (err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        if (obs !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic compareFront();
        expT e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("dp1", dp1, e.dp1);
            checkOutput("dp2", dp2, e.dp2);
            checkOutput("dp1Addr", dp1Addr, e.a1);
            checkOutput("dp2Addr", dp2Addr, e.a2);
            checkOutput("stall", stall, e.stall);
            checkOutput("dispatchPtr", dispatchPtr, e.ptr);
            checkOutput("freenum", freenum, e.fn);
            checkOutput("full", full, e.full);
            checkOutput("empty", empty, e.empty);
            checkOutput("flush", flush, e.flush);
            checkOutput("err", err, e.err);
        end
    endtask

    // Drive one cycle of stimulus, queue and compare its expected outputs,
    // then advance the model across the coming rising edge.
    task automatic applyStimulus(input bit r1, input bit r2, input int com,
                                 input int cptr, input bit prm, input bit rst);
        expT e;
        int  need;
        int  g;
        int  s;
        @(negedge clk);
        req1      = r1;
        req2      = r2;
        comnum    = 2'(com);
        commitPtr = ROB_SEL'(cptr);
        prmiss    = prm;
        resetIn   = rst;
        #1;
        need    = int'(r1) + int'(r1 & r2);
        e.stall = mRecov | prm | (need > mFn);
        e.dp1   = r1 & !e.stall & !rst;
        e.dp2   = r1 & r2 & !e.stall & !rst;
        e.a1    = mPtr;
        e.a2    = (mPtr + 1) % ROB_NUM;
        e.ptr   = mPtr;
        e.fn    = mFn;
        e.full  = (mFn == 0);
        e.empty = (mFn == ROB_NUM);
        e.flush = mRecov;
        e.err   = mErr;
        expQ.push_back(e);
        compareFront();
        g = int'(e.dp1) + int'(e.dp2);
        if (rst) begin
            mRecov = 0; mCnt = 0; mPtr = 0; mFn = ROB_NUM; mErr = 0;
        end else if (prm) begin
            mRecov = 1;
            mCnt   = RECOVER_CYC - 1;
            mPtr   = (cptr + com) % ROB_NUM;
            mFn    = ROB_NUM;
        end else if (!mRecov) begin
            mPtr = (mPtr + g) % ROB_NUM;
            s    = mFn - g + com;
            if (s > ROB_NUM) begin
                mFn  = ROB_NUM;
                mErr = 1;
            end else begin
                mFn = s;
            end
        end else begin
            if (mCnt == 0) mRecov = 0;
            else mCnt = mCnt - 1;
            mFn = (mFn + com > ROB_NUM) ? ROB_NUM : mFn + com;
        end
    endtask

    // Directed scenarios followed by a randomised run.
    initial begin
        resetIn   = 1'b1;
        req1      = 1'b0;
        req2      = 1'b0;
        comnum    = 2'd0;
        commitPtr = '0;
        prmiss    = 1'b0;
        mRecov = 0; mCnt = 0; mPtr = 0; mFn = ROB_NUM; mErr = 0;

        // Reset outranks a mispredict and suppresses grants.
        applyStimulus(1, 1, 0, 7, 1, 1);
        checkOutput("rstNoGrant", dp1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rstPtr", dispatchPtr, 0);
        checkOutput("rstFree", freenum, ROB_NUM);
        checkOutput("rstEmpty", empty, 1);
        checkOutput("rstFull", full, 0);
        checkOutput("rstFlush", flush, 0);
        checkOutput("rstErr", err, 0);

        // Fill the ROB with 32 granted pairs.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkOutput("fillAddr1", dp1Addr, 2 * i);
            checkOutput("fillAddr2", dp2Addr, 2 * i + 1);
            checkOutput("fillGrant2", dp2, 1);
        end
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("fullFlag", full, 1);
        checkOutput("fullStall", stall, 1);
        checkOutput("fullPtr", dispatchPtr, 0);

        // One free entry cannot take a pair; the commit is credited next cycle.
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0, 0);
        checkOutput("oneFreeStall", stall, 1);
        checkOutput("oneFreeDp1", dp1, 0);
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("creditFree", freenum, 2);
        checkOutput("creditGrant", dp2, 1);

        // Position the tail at 62 with ten free entries, then wrap.
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 27; i++) applyStimulus(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 2, 0, 0, 0);
        applyStimulus(1, 1, 2, 0, 0, 0);
        checkOutput("wrapAddr1", dp1Addr, 62);
        checkOutput("wrapAddr2", dp2Addr, 63);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrapPtr", dispatchPtr, 0);
        checkOutput("wrapFree", freenum, 10);

        // Mispredict at head 20 with one commit: two blocked cycles, then 21/22.
        applyStimulus(1, 1, 1, 20, 1, 0);
        checkOutput("missNoGrant", dp1, 0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 0, 0, 0);
            checkOutput("missFlush", flush, 1);
            checkOutput("missPtr", dispatchPtr, 21);
            checkOutput("missFree", freenum, ROB_NUM);
            checkOutput("missBlocked", dp1, 0);
        end
        applyStimulus(1, 1, 0, 0, 0, 0);
        checkOutput("resumeGrant", dp2, 1);
        checkOutput("resumeAddr1", dp1Addr, 21);
        checkOutput("resumeAddr2", dp2Addr, 22);

        // A second mispredict during recovery extends it.
        applyStimulus(0, 0, 0, 5, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 9, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("extFlush1", flush, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("extFlush2", flush, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("extDone", flush, 0);
        checkOutput("extPtr", dispatchPtr, 9);

        // Over-commit on an empty ROB sets the sticky error.
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("errSet", err, 1);
        checkOutput("errFree", freenum, ROB_NUM);
        applyStimulus(1, 1, 0, 3, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("errSticky", err, 1);

        // Reset in the middle of recovery, then reset with a pair request in RUN.
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midRstFlush", flush, 0);
        checkOutput("midRstErr", err, 0);
        applyStimulus(1, 1, 0, 0, 0, 1);
        checkOutput("rstRunNoGrant", dp1, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 2)), int'($urandom_range(0, ROB_NUM - 1)),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rob_dispatch_ctrl.md
ROB_DISPATCH_CTRL -- requirements
Module: rob_dispatch_ctrl

Interface
REQ-001 Parameter ROB_NUM, default 64, meaning: number of ROB entries; power of two.
REQ-002 Parameter ROB_SEL, default 6, meaning: log2(ROB_NUM), entry index width.
REQ-003 Parameter RECOVER_CYC, default 2, meaning: dispatch-blocked cycles after a mispredict; legal range 1..15.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 reset_i  in  1  synchronous active-high reset.
REQ-007 req1_i  in  1  first (older) instruction of the decode pair requests an ROB entry.
REQ-008 req2_i  in  1  second (younger) instruction requests an ROB entry.
REQ-009 comnum_i  in  2  entries retired by the ROB this cycle (0..2).
REQ-010 commit_ptr_i  in  ROB_SEL  current ROB head (oldest uncommitted entry).
REQ-011 prmiss_i  in  1  branch mispredict; squash all uncommitted entries.
REQ-012 dp1_o  out  1  entry granted to instruction 1 this cycle.
REQ-013 dp1_addr_o  out  ROB_SEL  ROB index for instruction 1.
REQ-014 dp2_o  out  1  entry granted to instruction 2 this cycle.
REQ-015 dp2_addr_o  out  ROB_SEL  ROB index for instruction 2.
REQ-016 stall_o  out  1  decode pair must be held.
REQ-017 dispatch_ptr_o  out  ROB_SEL  next free ROB index (tail).
REQ-018 freenum_o  out  ROB_SEL+1  count of free entries, 0..ROB_NUM.
REQ-019 full_o  out  1  freenum_o == 0.
REQ-020 empty_o  out  1  freenum_o == ROB_NUM.
REQ-021 flush_o  out  1  high while in RECOVER state.
REQ-022 err_o  out  1  sticky occupancy-underflow error.

Function
REQ-023 States: RUN and RECOVER; a RECOVER_CYC-wide down-counter (4 bits) times RECOVER.
REQ-024 dp1_addr_o = dispatch_ptr_o; dp2_addr_o = (dispatch_ptr_o + 1) mod ROB_NUM, combinational, valid regardless of grant.
REQ-025 need = req1_i + (req1_i & req2_i); req2_i without req1_i is ignored (in-order dispatch).
REQ-026 stall_o = (state==RECOVER) | prmiss_i | (need > freenum_o), combinational, using registered freenum_o (same-cycle commits not credited).
REQ-027 All-or-nothing pair grant: dp1_o = req1_i & ~stall_o; dp2_o = req1_i & req2_i & ~stall_o; never one of a requested pair.
REQ-028 RUN, no prmiss: dispatch_ptr <= dispatch_ptr + dp1_o + dp2_o mod ROB_NUM (wraps 63->0).
REQ-029 RUN, no prmiss: freenum <= freenum - (dp1_o+dp2_o) + comnum_i.
REQ-030 If freenum - grants + comnum_i > ROB_NUM: freenum <= ROB_NUM, err_o <= 1 (sticky until reset).
REQ-031 prmiss_i in any state: state <= RECOVER, counter <= RECOVER_CYC-1, dispatch_ptr <= commit_ptr_i + comnum_i mod ROB_NUM, freenum <= ROB_NUM, no grants that cycle.
REQ-032 RECOVER, no prmiss: counter decrements; when counter==0, state <= RUN next edge; freenum <= min(freenum + comnum_i, ROB_NUM) with no err_o; pointer held.
REQ-033 prmiss_i during RECOVER restarts the counter (RECOVER extended).
REQ-034 Dispatch resumes the first cycle state==RUN; total blocked cycles after prmiss cycle = RECOVER_CYC.
REQ-035 full_o, empty_o derived combinationally from registered freenum_o.

Reset
REQ-036 reset_i has priority over all inputs, including prmiss_i.
REQ-037 Reset values: state RUN, counter 0, dispatch_ptr_o 0, freenum_o ROB_NUM, err_o 0, flush_o 0, full_o 0, empty_o 1.
REQ-038 Reset asserted mid-RECOVER returns to RUN next edge; no grant in the reset cycle.

Verification
REQ-039 After reset, req1=req2=1 for 32 cycles, comnum=0 -> dp addrs 0/1, 2/3, ... 62/63; then full_o=1, stall_o=1, dispatch_ptr_o=0.
REQ-040 freenum=1, req1=req2=1 -> stall_o=1, dp1_o=dp2_o=0; next cycle comnum=1 credited -> freenum=2, pair granted.
REQ-041 dispatch_ptr=62, freenum=10, pair granted with comnum=2 -> dispatch_ptr=0, freenum=10.
REQ-042 prmiss with commit_ptr_i=20, comnum_i=1 -> next: dispatch_ptr=21, freenum=64, flush_o=1 for 2 cycles, grants 0; third cycle pair granted at 21/22.
REQ-043 prmiss again in second RECOVER cycle -> flush_o held 2 further cycles.
REQ-044 freenum=64, comnum=1 in RUN -> err_o=1, freenum stays 64, err_o clears only on reset.
